// File: rtl/sipo_pkg.sv
// Shared types and constants for the serial-in / parallel-out deserializer.
package sipo_pkg;

    localparam int DEFAULT_WIDTH = 3;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } sipo_state_t;

endpackage

// File: rtl/sipo_shift_reg.sv
// Bit-position shift register and frame bit counter for sipo_deser.
// With SIPO_DESER_PARITY_EN defined it also tracks a running even-parity check.
module sipo_shift_reg
    import sipo_pkg::*;
#(
    parameter int WIDTH     = DEFAULT_WIDTH,
    parameter int MSB_FIRST = 1,
    parameter int FRAME_LEN = WIDTH,
    parameter int CW        = $clog2(FRAME_LEN + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             shift,
    input  logic             serial_in,
    output logic [WIDTH-1:0] word_next,
    output logic             done,
    output logic             frame_ok
);

    logic [WIDTH-1:0] data_reg;
    logic [CW-1:0]    count_reg;
    logic [CW-1:0]    count_next;
    logic [CW-1:0]    bit_idx;
    logic             capture;

    assign capture = start | shift;
    // A start bit always lands at arrival index 0, whatever the current count.
    assign bit_idx = start ? '0 : count_reg;
    assign done    = shift && (count_reg == CW'(FRAME_LEN - 1));

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_bit
            localparam int ARR_IDX = (MSB_FIRST != 0) ? (WIDTH - 1 - gi) : gi;
            assign word_next[gi] = (capture && (bit_idx == CW'(ARR_IDX))) ? serial_in
                                 : (start ? 1'b0 : data_reg[gi]);
        end
    endgenerate

    always_comb begin
        count_next = count_reg;
        if (start)
            count_next = CW'(1);
        else if (done)
            count_next = '0;
        else if (shift)
            count_next = count_reg + CW'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            data_reg  <= '0;
            count_reg <= '0;
        end else begin
            count_reg <= count_next;
            if (capture)
                data_reg <= word_next;
        end
    end

`ifdef SIPO_DESER_PARITY_EN
    logic par_reg;
    logic par_next;

    // XOR of every captured bit including the one arriving now; zero means even parity.
    assign par_next = (start ? 1'b0 : par_reg) ^ serial_in;
    assign frame_ok = ~par_next;

    always_ff @(posedge clk) begin
        if (rst)
            par_reg <= 1'b0;
        else if (capture)
            par_reg <= par_next;
    end
`else
    assign frame_ok = 1'b1;
`endif

endmodule

// File: rtl/sipo_deser.sv
// Serial-to-parallel deserializer: framing FSM, output register and sticky overflow.
// Define SIPO_DESER_PARITY_EN for a trailing even-parity bit and the parity_err output.
module sipo_deser
    import sipo_pkg::*;
#(
    parameter int WIDTH     = DEFAULT_WIDTH,
    parameter int MSB_FIRST = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             serial_in,
    input  logic             bit_valid,
    input  logic             frame_start,
    input  logic             out_ready,
    output logic [WIDTH-1:0] parallel_out,
    output logic             out_valid,
    output logic             overflow
`ifdef SIPO_DESER_PARITY_EN
    ,
    output logic             parity_err
`endif
);

`ifdef SIPO_DESER_PARITY_EN
    localparam int FRAME_LEN = WIDTH + 1;
`else
    localparam int FRAME_LEN = WIDTH;
`endif

    sipo_state_t      state_reg;
    sipo_state_t      state_next;
    logic             in_shift;
    logic             start;
    logic             shift;
    logic             done;
    logic             frame_ok;
    logic [WIDTH-1:0] word_next;

    logic [WIDTH-1:0] out_reg;
    logic [WIDTH-1:0] out_next;
    logic             valid_reg;
    logic             valid_next;
    logic             ovf_reg;
    logic             ovf_next;

    assign start = bit_valid & frame_start;
    assign shift = bit_valid & ~frame_start & in_shift;

    sipo_shift_reg #(
        .WIDTH     (WIDTH),
        .MSB_FIRST (MSB_FIRST),
        .FRAME_LEN (FRAME_LEN)
    ) u_shift (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .shift     (shift),
        .serial_in (serial_in),
        .word_next (word_next),
        .done      (done),
        .frame_ok  (frame_ok)
    );

    always_ff @(posedge clk) begin
        if (rst)
            state_reg <= IDLE;
        else
            state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        if (start)
            state_next = SHIFT;
        else if (done)
            state_next = IDLE;
    end

    always_comb begin
        in_shift = (state_reg == SHIFT);
    end

    // A finished word takes the slot if it is empty or being drained this cycle.
    always_comb begin
        out_next   = out_reg;
        valid_next = valid_reg;
        ovf_next   = ovf_reg;
        if (done && frame_ok) begin
            if (!valid_reg || out_ready) begin
                out_next   = word_next;
                valid_next = 1'b1;
            end else begin
                ovf_next = 1'b1;
            end
        end else if (valid_reg && out_ready) begin
            valid_next = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_reg   <= '0;
            valid_reg <= 1'b0;
            ovf_reg   <= 1'b0;
        end else begin
            out_reg   <= out_next;
            valid_reg <= valid_next;
            ovf_reg   <= ovf_next;
        end
    end

    assign parallel_out = out_reg;
    assign out_valid    = valid_reg;
    assign overflow     = ovf_reg;

`ifdef SIPO_DESER_PARITY_EN
    logic perr_reg;

    always_ff @(posedge clk) begin
        if (rst)
            perr_reg <= 1'b0;
        else
            perr_reg <= done & ~frame_ok;
    end

    assign parity_err = perr_reg;
`endif

endmodule

// File: tb/tb_sipo_deser.sv
// Randomized and directed bench for sipo_deser, MSB-first and LSB-first instances side by side.
module tb_sipo_deser;

    localparam int W = 3;
`ifdef SIPO_DESER_PARITY_EN
    localparam int FLEN = W + 1;
`else
    localparam int FLEN = W;
`endif

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         serial_in = 1'b0;
    logic         bit_valid = 1'b0;
    logic         frame_start = 1'b0;
    logic         out_ready = 1'b0;
    logic [W-1:0] pout_m, pout_l;
    logic         valid_m, valid_l, ovf_m, ovf_l;
`ifdef SIPO_DESER_PARITY_EN
    logic         perr_m, perr_l;
`endif

    always #5 clk = ~clk;

    sipo_deser #(.WIDTH(W), .MSB_FIRST(1)) dut_m (
        .clk          (clk),
        .rst          (rst),
        .serial_in    (serial_in),
        .bit_valid    (bit_valid),
        .frame_start  (frame_start),
        .out_ready    (out_ready),
        .parallel_out (pout_m),
        .out_valid    (valid_m),
        .overflow     (ovf_m)
`ifdef SIPO_DESER_PARITY_EN
        ,
        .parity_err   (perr_m)
`endif
    );

    sipo_deser #(.WIDTH(W), .MSB_FIRST(0)) dut_l (
        .clk          (clk),
        .rst          (rst),
        .serial_in    (serial_in),
        .bit_valid    (bit_valid),
        .frame_start  (frame_start),
        .out_ready    (out_ready),
        .parallel_out (pout_l),
        .out_valid    (valid_l),
        .overflow     (ovf_l)
`ifdef SIPO_DESER_PARITY_EN
        ,
        .parity_err   (perr_l)
`endif
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: received bits of the open frame, plus the visible output state.
    bit           q[$];
    logic         mv   = 1'b0;
    logic [W-1:0] mo_m = '0;
    logic [W-1:0] mo_l = '0;
    logic         movf = 1'b0;
    logic         mperr = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step(input logic sv, input logic bv, input logic fs, input logic rdy, input logic rs);
        bit           done;
        bit           ok;
        int           ones;
        logic [W-1:0] wm;
        logic [W-1:0] wl;
        serial_in   = sv;
        bit_valid   = bv;
        frame_start = fs;
        out_ready   = rdy;
        rst         = rs;
        done = 0;
        ok   = 1;
        wm   = '0;
        wl   = '0;
        if (rs) begin
            q.delete();
            mv = 0; mo_m = '0; mo_l = '0; movf = 0; mperr = 0;
        end else begin
            if (bv && fs) begin
                q.delete();
                q.push_back(sv);
            end else if (bv && q.size() != 0) begin
                q.push_back(sv);
                if (q.size() == FLEN) begin
                    done = 1;
                    ones = 0;
                    for (int i = 0; i < FLEN; i++) ones += int'(q[i]);
                    ok = (FLEN == W) || (ones % 2 == 0);
                    for (int i = 0; i < W; i++) begin
                        wm[W-1-i] = q[i];
                        wl[i]     = q[i];
                    end
                    q.delete();
                end
            end
            mperr = done && !ok;
            if (done && ok) begin
                if (!mv || rdy) begin
                    mo_m = wm; mo_l = wl; mv = 1;
                    $display("[TB] word msb=%b lsb=%b loaded", wm, wl);
                end else begin
                    movf = 1;
                    $display("[TB] word msb=%b dropped, output busy", wm);
                end
            end else if (done) begin
                $display("[TB] word msb=%b dropped, bad parity", wm);
            end else if (mv && rdy) begin
                mv = 0;
            end
        end
        @(posedge clk);
        #1;
        check_eq("out_msb", 32'(pout_m), 32'(mo_m));
        check_eq("out_lsb", 32'(pout_l), 32'(mo_l));
        check_eq("valid",   32'(valid_m), 32'(mv));
        check_eq("valid_l", 32'(valid_l), 32'(mv));
        check_eq("ovf",     32'(ovf_m), 32'(movf));
        check_eq("ovf_l",   32'(ovf_l), 32'(movf));
`ifdef SIPO_DESER_PARITY_EN
        check_eq("perr",    32'(perr_m), 32'(mperr));
        check_eq("perr_l",  32'(perr_l), 32'(mperr));
`endif
    endtask

    task automatic idle(input int n, input logic rdy);
        for (int i = 0; i < n; i++) step(1'($urandom), 1'b0, 1'($urandom), rdy, 1'b0);
    endtask

    // data[2] is sent first; a parity bit (inverted if bad_par) follows when enabled.
    task automatic send_frame(input logic [2:0] data, input int gap_max, input logic rdy, input logic bad_par);
        logic b[4];
        b[0] = data[2];
        b[1] = data[1];
        b[2] = data[0];
        b[3] = (^data) ^ bad_par;
        for (int i = 0; i < FLEN; i++) begin
            if (i > 0) idle($urandom_range(0, gap_max), rdy);
            step(b[i], 1'b1, (i == 0), rdy, 1'b0);
        end
    endtask

    initial begin
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
        check_eq("rst_out", 32'(pout_m), 32'h0);
        check_eq("rst_valid", 32'(valid_m), 32'h0);

        // 0,0,1 with ready high: word 001, valid for exactly one cycle
        send_frame(3'b001, 0, 1'b1, 1'b0);
        check_eq("basic_word", 32'(pout_m), 32'h1);
        check_eq("basic_valid", 32'(valid_m), 32'h1);
        idle(1, 1'b1);
        check_eq("basic_valid_drop", 32'(valid_m), 32'h0);

        // LSB-first ordering
        send_frame(3'b100, 0, 1'b1, 1'b0);
        check_eq("lsb_word", 32'(pout_l), 32'h1);
        check_eq("msb_word", 32'(pout_m), 32'h4);
        idle(1, 1'b1);

        // Back-to-back words with ready low: second word lost, overflow sticks
        send_frame(3'b100, 0, 1'b0, 1'b0);
        send_frame(3'b101, 0, 1'b0, 1'b0);
        check_eq("ovf_hold", 32'(pout_m), 32'h4);
        check_eq("ovf_flag", 32'(ovf_m), 32'h1);
        idle(1, 1'b1);
        check_eq("ovf_drain", 32'(valid_m), 32'h0);
        check_eq("ovf_sticky", 32'(ovf_m), 32'h1);
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);

        // Restart after two bits: only the restarted frame appears
        step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        send_frame(3'b101, 0, 1'b1, 1'b0);
        check_eq("restart_word", 32'(pout_m), 32'h5);
        idle(1, 1'b1);

        // Reset mid-frame, then bits without frame_start are ignored
        step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
        check_eq("midrst_out", 32'(pout_m), 32'h0);
        for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        check_eq("idle_ignore", 32'(valid_m), 32'h0);

        // Gapped bit_valid gives the same word as gap-free
        for (int k = 0; k < 6; k++) begin
            logic [2:0] d;
            d = 3'($urandom);
            send_frame(d, 3, 1'b1, 1'b0);
            check_eq("gap_word", 32'(pout_m), 32'(d));
            idle(1, 1'b1);
        end

`ifdef SIPO_DESER_PARITY_EN
        send_frame(3'b101, 0, 1'b1, 1'b0);
        check_eq("par_ok_word", 32'(pout_m), 32'h5);
        idle(1, 1'b1);
        send_frame(3'b101, 1, 1'b1, 1'b1);
        check_eq("par_bad_valid", 32'(valid_m), 32'h0);
        check_eq("par_bad_pulse", 32'(perr_m), 32'h1);
        idle(1, 1'b1);
        check_eq("par_pulse_end", 32'(perr_m), 32'h0);
`endif

        for (int i = 0; i < 600; i++)
            step(1'($urandom), ($urandom % 3) != 0, ($urandom % 8) == 0,
                 ($urandom % 4) != 0, ($urandom % 64) == 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
